// File: rtl/spi_byte_master.sv
// ---------------------------------------------------------------------------
// spi_byte_master
//
// Purpose:
//   SPI mode-0 master that shifts one DATA_WIDTH-bit word per start request,
//   MSB first. spi_sck idles low. The master samples spi_miso on each rising
//   spi_sck edge and changes spi_mosi on each falling edge. A transfer can
//   hold spi_nss low after it finishes, so that following words form one
//   frame.
//
// Parameters:
//   DATA_WIDTH  - bits per transfer (>= 2)
//   HALF_PERIOD - clk cycles per spi_sck half-period (>= 1)
//
// Optional feature:
//   SPI_BYTE_MASTER_CLKDIV_EN - when defined, the clk_div input port exists.
//   The half-period is then captured from clk_div when a start is accepted.
//   A value of 0 is treated as 1.
//
// Ports:
//   clk      in   system clock, rising edge
//   _reset   in   synchronous active-low reset
//   start    in   transfer request (ignored while busy)
//   tx_data  in   word to send, captured on accept
//   hold     in   keep spi_nss low after this word, captured on accept
//   clk_div  in   runtime half-period (only with SPI_BYTE_MASTER_CLKDIV_EN)
//   busy     out  transfer in progress
//   done     out  one-cycle pulse at transfer end
//   rx_data  out  last received word
//   spi_nss  out  active-low slave select
//   spi_sck  out  serial clock
//   spi_mosi out  serial data out
//   spi_miso in   serial data in
// ---------------------------------------------------------------------------
module spi_byte_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  hold,
`ifdef SPI_BYTE_MASTER_CLKDIV_EN
    input  logic [7:0]            clk_div,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_nss,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEAD   = 3'd1;
    localparam logic [2:0] ST_HIGH   = 3'd2;
    localparam logic [2:0] ST_LOW    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

`ifdef SPI_BYTE_MASTER_CLKDIV_EN
    localparam int CNT_W = 8;
`else
    localparam int CNT_W = ($clog2(HALF_PERIOD + 1) < 1) ? 1 : $clog2(HALF_PERIOD + 1);
`endif
    localparam int BIT_W = ($clog2(DATA_WIDTH) < 1) ? 1 : $clog2(DATA_WIDTH);

    logic [2:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic                  hold_r;
    logic [CNT_W-1:0]      half_s;
    logic                  half_last_s;
    logic                  bit_last_s;

`ifdef SPI_BYTE_MASTER_CLKDIV_EN
    logic [CNT_W-1:0]      half_r;
    logic [CNT_W-1:0]      half_next_s;

    // Clamp a zero divider to one so that a half-period always lasts at least one cycle.
    always_comb begin
        half_next_s = clk_div;
        if (clk_div == 8'd0) begin
            half_next_s = 8'd1;
        end else begin
            half_next_s = clk_div;
        end
    end

    assign half_s = half_r;
`else
    assign half_s = CNT_W'(HALF_PERIOD);
`endif

    // A phase (LEAD, HIGH or LOW) ends on its H-th cycle. cnt_r counts 0..H-1.
    always_comb begin
        half_last_s = (cnt_r == (half_s - CNT_W'(1)));
        bit_last_s  = (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));
    end

    // Transfer sequencer, with shift registers and registered SPI/handshake outputs.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            tx_sh_r   <= {DATA_WIDTH{1'b0}};
            rx_sh_r   <= {DATA_WIDTH{1'b0}};
            hold_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= {DATA_WIDTH{1'b0}};
            spi_nss   <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
`ifdef SPI_BYTE_MASTER_CLKDIV_EN
            half_r    <= 8'd1;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                // FINISH is the cycle after done. It accepts a start just as IDLE
                // does, which allows back-to-back words.
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        tx_sh_r   <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                        spi_mosi  <= tx_data[DATA_WIDTH-1];
                        hold_r    <= hold;
                        busy      <= 1'b1;
                        spi_nss   <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_cnt_r <= {BIT_W{1'b0}};
`ifdef SPI_BYTE_MASTER_CLKDIV_EN
                        half_r    <= half_next_s;
`endif
                        state_r   <= ST_LEAD;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LEAD: begin
                    if (half_last_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        spi_sck <= 1'b1;
                        rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], spi_miso};
                        state_r <= ST_HIGH;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (half_last_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        spi_sck  <= 1'b0;
                        // After the last bit the zeros that were shifted in reach
                        // spi_mosi, so the line is already 0 when the block returns to idle.
                        spi_mosi <= tx_sh_r[DATA_WIDTH-1];
                        tx_sh_r  <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
                        state_r  <= ST_LOW;
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (half_last_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (bit_last_s) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            rx_data  <= rx_sh_r;
                            spi_nss  <= ~hold_r;
                            spi_mosi <= 1'b0;
                            state_r  <= ST_FINISH;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            spi_sck   <= 1'b1;
                            rx_sh_r   <= {rx_sh_r[DATA_WIDTH-2:0], spi_miso};
                            state_r   <= ST_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= {CNT_W{1'b0}};
                    busy     <= 1'b0;
                    spi_nss  <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the bits per transfer.
REQ-002 The block SHALL have parameter HALF_PERIOD, default 2, giving the clk cycles per spi_sck half-period (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port _reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: transfer request, sampled on each clk edge.
REQ-006 The block SHALL have port tx_data, input, DATA_WIDTH bits: byte to transmit, captured on start accept.
REQ-007 The block SHALL have port hold, input, 1 bit: keeps spi_nss low after the byte, captured on start accept.
REQ-008 The block SHALL have port busy, output, 1 bit: transfer in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-010 The block SHALL have port rx_data, output, DATA_WIDTH bits: last received byte.
REQ-011 The block SHALL have port spi_nss, output, 1 bit: active-low slave select.
REQ-012 The block SHALL have port spi_sck, output, 1 bit: serial clock (mode 0, idle low).
REQ-013 The block SHALL have port spi_mosi, output, 1 bit: serial data out, MSB first.
REQ-014 The block SHALL have port spi_miso, input, 1 bit: serial data in.
REQ-015 The block SHALL have port clk_div, input, 8 bits: runtime half-period, present only with SPI_BYTE_MASTER_CLKDIV_EN.

Function
REQ-016 The block SHALL implement states IDLE, LEAD, HIGH, LOW and FINISH; H denotes the effective half-period.
REQ-017 In IDLE, start=1 with busy=0 SHALL be accepted at that edge k: latch tx_data and hold, set busy=1, drive spi_nss=0, drive spi_mosi with the MSB, enter LEAD.
REQ-018 A start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the current transfer.
REQ-019 LEAD SHALL last H cycles with spi_sck=0, after which the state becomes HIGH.
REQ-020 On entering HIGH, at edge k+H+2H*i for bit i (0..DATA_WIDTH-1), spi_sck SHALL go 1 and spi_miso SHALL be shifted into the receive register LSB at that same edge.
REQ-021 HIGH SHALL last H cycles, then spi_sck SHALL go 0, the state SHALL become LOW, and spi_mosi SHALL present the next bit at that same edge.
REQ-022 LOW SHALL last H cycles; after the last bit's LOW the state SHALL become FINISH, otherwise HIGH.
REQ-023 At edge k+(2*DATA_WIDTH+1)*H (34 clk cycles for defaults), done SHALL be 1 for one cycle, rx_data SHALL load the receive register, busy SHALL go 0, and the state SHALL return to IDLE.
REQ-024 At the done edge, spi_nss SHALL return to 1 if the latched hold=0, and SHALL stay 0 if hold=1.
REQ-025 A start accepted while spi_nss=0 from a held transfer SHALL continue the frame with no spi_nss pulse.
REQ-026 A start accepted on the cycle after done SHALL be legal, giving back-to-back transfers with no spi_sck glitch.
REQ-027 rx_data SHALL hold its value between done pulses.
REQ-028 spi_mosi SHALL be 0 in IDLE.
REQ-029 spi_sck SHALL change only on the edges defined above.

Reset
REQ-030 While _reset=0 at a clk edge, the block SHALL force busy=0, done=0, rx_data=0, spi_nss=1, spi_sck=0, spi_mosi=0, clear the counters, latched hold and shift registers, and enter IDLE.
REQ-031 A reset asserted mid-transfer SHALL abort it on that edge with no done pulse, and spi_nss SHALL rise even if hold was latched.
REQ-032 A start coincident with _reset=0 SHALL be ignored.

Configuration
REQ-033 With SPI_BYTE_MASTER_CLKDIV_EN defined, port clk_div SHALL exist, H SHALL be clk_div captured on start accept, and clk_div=0 SHALL be treated as 1.
REQ-034 Without SPI_BYTE_MASTER_CLKDIV_EN, clk_div SHALL be absent and H SHALL be HALF_PERIOD.

Verification
REQ-035 Loopback spi_miso=spi_mosi, defaults, tx_data=0xA5, hold=0 -> spi_nss low for 34 cycles, 8 sck pulses, done at k+34, rx_data=0xA5, spi_nss=1.
REQ-036 Inverting slave spi_miso=~spi_mosi, tx_data=0x41 -> rx_data=0xBE.
REQ-037 Three bytes 0x01,0x02,0x04 with hold=1,1,0 issued on the cycle after each done -> spi_nss stays low across all 24 bits and rises only at the third done.
REQ-038 start pulsed again at k+5 during a 0x3C transfer -> ignored, single done, rx_data correct.
REQ-039 _reset=0 at k+10 with hold=1 -> next edge spi_nss=1, busy=0, rx_data=0, no done.
REQ-040 With SPI_BYTE_MASTER_CLKDIV_EN: clk_div=5 -> done at k+85; clk_div=0 -> done at k+17.
